move_tx_formatter: RTL and testbench

- Takes the move pair chosen by the Connect6 move engine and serialises it as an ASCII byte stream toward the host link (UART TX FIFO).
- Sits on the outbound side of the board logic, opposite the inbound opponent-move path.
- Each stone is a column letter ('A'+x) followed by a two-digit row (y+1, '01'..'19'). A pair is two stones followed by a terminator.
- Single-stone mode covers the opening move.

---
 rtl/move_tx_formatter_if.sv | 27 ++
 rtl/move_tx_formatter.sv | 145 ++++++++++++++
 tb/tb_move_tx_formatter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/move_tx_formatter_if.sv
// Move-in / ASCII-byte-out bundle between the move engine, the formatter and the UART TX FIFO.
interface move_tx_formatter_if #(
  parameter int CNT_W = 16
);
  logic             move_valid;
  logic             move_ready;
  logic             single_stone;
  logic [5:0]       x_a;
  logic [5:0]       y_a;
  logic [5:0]       x_b;
  logic [5:0]       y_b;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             move_err;
  logic [CNT_W-1:0] msg_count;

  modport master (
    output move_valid, single_stone, x_a, y_a, x_b, y_b, tx_ready,
    input  move_ready, tx_data, tx_valid, move_err, msg_count
  );

  modport slave (
    input  move_valid, single_stone, x_a, y_a, x_b, y_b, tx_ready,
    output move_ready, tx_data, tx_valid, move_err, msg_count
  );
endinterface

// File: rtl/move_tx_formatter.sv
// Serialises a Connect6 move (one or two stones) as "<col><row2>..." ASCII plus a terminator byte.
module move_tx_formatter #(
  parameter int         BOARD_SIZE = 19,
  parameter logic [7:0] TERM_CHAR  = 8'h0A,
  parameter int         CNT_W      = 16
) (
  input logic clk,
  input logic rst_n,
  move_tx_formatter_if.slave io_bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ERR,
    DONE
  } state_t;

  localparam logic [5:0] MAX_COORD = 6'(BOARD_SIZE - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [5:0]       r_xa;
  logic [5:0]       r_ya;
  logic [5:0]       r_xb;
  logic [5:0]       r_yb;
  logic             r_single;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_count;

  logic       w_accept;
  logic       w_coordOk;
  logic       w_lastByte;
  logic       w_txFire;
  logic [7:0] w_txByte;
  logic       w_moveReady;
  logic       w_txValid;
  logic [7:0] w_txData;
  logic       w_moveErr;

  function automatic logic [7:0] colChar(input logic [5:0] x);
    return 8'h41 + {2'b00, x};
  endfunction

  // Rows are 1-based on the wire, so y=18 must become "19" without overflow.
  function automatic logic [7:0] tensChar(input logic [5:0] y);
    logic [5:0] row;
    row = y + 6'd1;
    return (row >= 6'd10) ? 8'h31 : 8'h30;
  endfunction

  function automatic logic [7:0] onesChar(input logic [5:0] y);
    logic [5:0] row;
    row = y + 6'd1;
    return (row >= 6'd10) ? (8'h30 + {2'b00, row - 6'd10}) : (8'h30 + {2'b00, row});
  endfunction

  assign w_accept   = io_bus.move_valid && (r_state == IDLE);
  assign w_coordOk  = (io_bus.x_a <= MAX_COORD) && (io_bus.y_a <= MAX_COORD) &&
                      (io_bus.single_stone ||
                       ((io_bus.x_b <= MAX_COORD) && (io_bus.y_b <= MAX_COORD)));
  assign w_lastByte = r_single ? (r_idx == 3'd3) : (r_idx == 3'd6);
  assign w_txFire   = (r_state == SEND) && io_bus.tx_ready;

  always_comb begin
    w_txByte = TERM_CHAR;
    case (r_idx)
      3'd0: w_txByte = colChar(r_xa);
      3'd1: w_txByte = tensChar(r_ya);
      3'd2: w_txByte = onesChar(r_ya);
      3'd3: w_txByte = r_single ? TERM_CHAR : colChar(r_xb);
      3'd4: w_txByte = tensChar(r_yb);
      3'd5: w_txByte = onesChar(r_yb);
      default: w_txByte = TERM_CHAR;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_moveReady = 1'b0;
    w_txValid   = 1'b0;
    w_txData    = 8'h00;
    w_moveErr   = 1'b0;
    case (r_state)
      IDLE: begin
        w_moveReady = 1'b1;
        if (io_bus.move_valid) begin
          w_nextState = w_coordOk ? SEND : ERR;
        end
      end
      ERR: begin
        w_moveErr   = 1'b1;
        w_nextState = IDLE;
      end
      SEND: begin
        w_txValid = 1'b1;
        w_txData  = w_txByte;
        if (io_bus.tx_ready && w_lastByte) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_xa     <= '0;
      r_ya     <= '0;
      r_xb     <= '0;
      r_yb     <= '0;
      r_single <= 1'b0;
      r_idx    <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_xa     <= io_bus.x_a;
        r_ya     <= io_bus.y_a;
        r_xb     <= io_bus.x_b;
        r_yb     <= io_bus.y_b;
        r_single <= io_bus.single_stone;
        r_idx    <= '0;
      end else if (w_txFire) begin
        r_idx <= r_idx + 3'd1;
      end
      if (r_state == DONE) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign io_bus.move_ready = w_moveReady;
  assign io_bus.tx_valid   = w_txValid;
  assign io_bus.tx_data    = w_txData;
  assign io_bus.move_err   = w_moveErr;
  assign io_bus.msg_count  = r_count;

endmodule

// File: tb/tb_move_tx_formatter.sv
// Randomised and directed bench for move_tx_formatter; expected bytes come from printf-style formatting of each move.
module tb_move_tx_formatter;

  localparam int CNT_W      = 3;
  localparam int BOARD_SIZE = 19;

  logic clk = 1'b0;
  logic rst_n;

  int checkCount = 0;
  int passCount  = 0;
  logic [CNT_W-1:0] modelCount = '0;
  logic [7:0] expQ[$];

  move_tx_formatter_if #(.CNT_W(CNT_W)) bus ();

  move_tx_formatter #(
    .BOARD_SIZE(BOARD_SIZE),
    .TERM_CHAR (8'h0A),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The wire format of one stone is simply printf("%c%02d", 'A'+x, y+1).
  task automatic buildExpected(input bit single, input int xa, input int ya, input int xb, input int yb);
    string st;
    expQ.delete();
    st = $sformatf("%c%02d", 65 + xa, ya + 1);
    for (int i = 0; i < 3; i++) expQ.push_back(st[i]);
    if (!single) begin
      st = $sformatf("%c%02d", 65 + xb, yb + 1);
      for (int i = 0; i < 3; i++) expQ.push_back(st[i]);
    end
    expQ.push_back(8'h0A);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scrambleInputs();
    bus.single_stone = 1'($urandom);
    bus.x_a = 6'($urandom);
    bus.y_a = 6'($urandom);
    bus.x_b = 6'($urandom);
    bus.y_b = 6'($urandom);
  endtask

  // readyMode: 0 = tx_ready always high, 1 = random, 2 = pattern 1,0,0 repeating.
  task automatic applyStimulus(input bit single, input int xa, input int ya, input int xb, input int yb,
                               input int readyMode, input int resetAfter);
    int  waitCycles;
    int  idx;
    int  cyc;
    bit  legal;
    bit  rdy;
    waitCycles = 0;
    while (bus.move_ready !== 1'b1 && waitCycles < 20) begin
      nextCycle();
      waitCycles++;
    end
    checkOutput("moveReadyIdle", bus.move_ready, 1);
    if (bus.move_ready !== 1'b1) return;

    legal = (xa < BOARD_SIZE) && (ya < BOARD_SIZE) && (single || ((xb < BOARD_SIZE) && (yb < BOARD_SIZE)));
    buildExpected(single, xa, ya, xb, yb);
    bus.move_valid   = 1'b1;
    bus.single_stone = single;
    bus.x_a = 6'(xa);
    bus.y_a = 6'(ya);
    bus.x_b = 6'(xb);
    bus.y_b = 6'(yb);
    nextCycle();
    bus.move_valid = 1'($urandom);
    scrambleInputs();

    if (!legal) begin
      checkOutput("moveErr", bus.move_err, 1);
      checkOutput("errNoTx", bus.tx_valid, 0);
      checkOutput("errReady", bus.move_ready, 0);
      bus.tx_ready = 1'($urandom);
      nextCycle();
      bus.move_valid = 1'b0;
      checkOutput("errPulseEnd", bus.move_err, 0);
      checkOutput("errReadyBack", bus.move_ready, 1);
      checkOutput("errCount", bus.msg_count, modelCount);
      return;
    end

    idx = 0;
    cyc = 0;
    while (idx < expQ.size() && cyc < 400) begin
      checkOutput("txValid", bus.tx_valid, 1);
      checkOutput("txData", bus.tx_data, expQ[idx]);
      checkOutput("busyReady", bus.move_ready, 0);
      checkOutput("noErr", bus.move_err, 0);
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 3 == 0);
      endcase
      bus.tx_ready   = rdy;
      bus.move_valid = 1'($urandom);
      nextCycle();
      cyc++;
      if (rdy) idx++;
      if (resetAfter >= 0 && rdy && idx == resetAfter) begin
        bus.move_valid = 1'b0;
        rst_n = 1'b0;
        nextCycle();
        checkOutput("rstTxValid", bus.tx_valid, 0);
        checkOutput("rstTxData", bus.tx_data, 0);
        checkOutput("rstCount", bus.msg_count, 0);
        rst_n = 1'b1;
        modelCount = '0;
        nextCycle();
        checkOutput("rstReady", bus.move_ready, 1);
        return;
      end
    end
    if (idx < expQ.size()) begin
      checkOutput("sendTimeout", idx, expQ.size());
      bus.move_valid = 1'b0;
      return;
    end

    checkOutput("doneValid", bus.tx_valid, 0);
    checkOutput("doneReady", bus.move_ready, 0);
    bus.tx_ready = 1'($urandom);
    nextCycle();
    bus.move_valid = 1'b0;
    modelCount = modelCount + 1'b1;
    checkOutput("msgCount", bus.msg_count, modelCount);
    checkOutput("readyAgain", bus.move_ready, 1);
  endtask

  function automatic int randCoord();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(19, 63)) : int'($urandom_range(0, 18));
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.move_valid   = 1'b0;
    bus.single_stone = 1'b0;
    bus.x_a = '0;
    bus.y_a = '0;
    bus.x_b = '0;
    bus.y_b = '0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetTxValid", bus.tx_valid, 0);
    checkOutput("resetTxData", bus.tx_data, 0);
    checkOutput("resetErr", bus.move_err, 0);
    checkOutput("resetCount", bus.msg_count, 0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("resetReady", bus.move_ready, 1);

    applyStimulus(1'b0, 3, 9, 10, 4, 0, -1);
    applyStimulus(1'b1, 9, 9, 63, 0, 0, -1);
    applyStimulus(1'b0, 0, 0, 18, 18, 2, -1);
    applyStimulus(1'b0, 3, 3, 19, 2, 0, -1);
    applyStimulus(1'b0, 2, 2, 2, 19, 1, -1);
    applyStimulus(1'b1, 19, 0, 0, 0, 0, -1);
    applyStimulus(1'b1, 0, 63, 0, 0, 0, -1);
    applyStimulus(1'b1, 18, 18, 40, 40, 1, -1);
    applyStimulus(1'b0, 5, 6, 7, 8, 0, 3);
    applyStimulus(1'b0, 1, 2, 3, 4, 0, -1);

    for (int n = 0; n < 40; n++) begin
      bus.tx_ready = 1'($urandom);
      repeat ($urandom_range(0, 2)) nextCycle();
      applyStimulus(1'($urandom_range(0, 3) == 0), randCoord(), randCoord(), randCoord(), randCoord(),
                    int'($urandom_range(0, 2)), -1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
